mem_stage_lat: RTL and testbench

- Parametrised successor to the single-cycle Y86-64 pipeline memory stage; sits between the M and W pipeline registers.
- Owns the byte-addressed data memory and performs the loads/stores for rmmovq, mrmovq, call, ret, pushq and popq.
- Adds configurable memory latency with a busy handshake back to pipeline control.
- Adds out-of-range address detection (ADR status), a W_bubble input and an asynchronous reset.

---
 rtl/mem_stage_lat.sv | 152 +++++++++++++++
 tb/tb_mem_stage_lat.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lat.sv
// Y86-64 memory stage: byte-addressed data memory, configurable access latency with a
// busy handshake, out-of-range address detection, and the W pipeline register.
module mem_stage_lat #(
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 1024,
    parameter int MEM_LAT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        M_icode,
    input  logic [DATA_W-1:0] M_valA,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic [1:0]        M_stat,
    input  logic              W_stall,
    input  logic              W_bubble,
    output logic              m_busy,
    output logic [1:0]        m_stat,
    output logic [DATA_W-1:0] m_valM,
    output logic [3:0]        W_icode,
    output logic [3:0]        W_dstE,
    output logic [3:0]        W_dstM,
    output logic [DATA_W-1:0] W_valE,
    output logic [DATA_W-1:0] W_valM,
    output logic [1:0]        W_stat
);

    localparam int NB = DATA_W / 8;
    localparam int AW = $clog2(MEM_BYTES);
    localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam logic [DATA_W-1:0] MAX_ADDR = DATA_W'(MEM_BYTES - NB);
    // The IDLE cycle is the first busy cycle, so WAIT only needs MEM_LAT-1 more.
    localparam logic [CW-1:0] CNT_LOAD = CW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);
    localparam logic HAS_LAT = (MEM_LAT > 0);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [1:0] S_AOK    = 2'd0;
    localparam logic [1:0] S_ADR    = 2'd2;

    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t            state_reg;
    logic [CW-1:0]     cnt_reg;
    logic [7:0]        mem [MEM_BYTES];

    logic              is_read;
    logic              is_write;
    logic              addr_from_a;
    logic [DATA_W-1:0] addr;
    logic              access;
    logic              fault;
    logic              valid_access;
    logic [AW-1:0]     base;
    logic [DATA_W-1:0] rd_data;
    logic              complete;
    logic              commit;

    assign addr_from_a  = (M_icode == I_RET) || (M_icode == I_POPQ);
    assign is_read      = (M_icode == I_MRMOVQ) || addr_from_a;
    assign is_write     = (M_icode == I_RMMOVQ) || (M_icode == I_CALL) || (M_icode == I_PUSHQ);
    assign addr         = addr_from_a ? M_valA : M_valE;
    assign access       = (is_read || is_write) && (M_stat == S_AOK);
    assign fault        = access && (addr > MAX_ADDR);
    assign valid_access = access && !fault;
    // A faulting address is never used to index memory, so lane indices cannot overflow.
    assign base         = valid_access ? addr[AW-1:0] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign rd_data[8*gi +: 8] = mem[base + AW'(gi)];
        end
    endgenerate

    assign m_valM   = (valid_access && is_read) ? rd_data : '0;
    assign m_stat   = fault ? S_ADR : M_stat;
    assign m_busy   = valid_access && ((state_reg == ST_IDLE) ? HAS_LAT : (cnt_reg != '0));
    assign complete = valid_access && !m_busy && !W_stall;
    assign commit   = complete && is_write && !W_bubble && rst_n;

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < NB; i++) begin
                mem[base + AW'(i)] <= M_valA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            W_icode   <= I_NOP;
            W_dstE    <= R_NONE;
            W_dstM    <= R_NONE;
            W_valE    <= '0;
            W_valM    <= '0;
            W_stat    <= S_AOK;
        end else begin
            if (!W_stall) begin
                if (W_bubble || m_busy) begin
                    W_icode <= I_NOP;
                    W_dstE  <= R_NONE;
                    W_dstM  <= R_NONE;
                    W_valE  <= '0;
                    W_valM  <= '0;
                    W_stat  <= S_AOK;
                end else begin
                    W_icode <= M_icode;
                    W_dstE  <= M_dstE;
                    W_dstM  <= M_dstM;
                    W_valE  <= M_valE;
                    W_valM  <= m_valM;
                    W_stat  <= m_stat;
                end
            end

            if (!valid_access || (W_bubble && !W_stall)) begin
                state_reg <= ST_IDLE;
                cnt_reg   <= '0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (HAS_LAT) begin
                            state_reg <= ST_WAIT;
                            cnt_reg   <= CNT_LOAD;
                        end
                    end
                    ST_WAIT: begin
                        if (!W_stall) begin
                            if (cnt_reg != '0) begin
                                cnt_reg <= cnt_reg - CW'(1);
                            end else begin
                                state_reg <= ST_IDLE;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_lat.sv
// Scoreboard bench for mem_stage_lat: one instance with MEM_LAT=0 and one with MEM_LAT=2,
// directed Y86-64 memory ops with hand-computed W register contents.
module tb_mem_stage_lat;

    typedef struct packed {
        logic        dut;
        logic [3:0]  icode;
        logic [63:0] vale;
        logic [63:0] valm;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [1:0]  stat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [3:0]  m_icode   [2];
    logic [63:0] m_vala    [2];
    logic [63:0] m_vale    [2];
    logic [3:0]  m_dste    [2];
    logic [3:0]  m_dstm    [2];
    logic [1:0]  m_stat_in [2];
    logic        w_stall   [2];
    logic        w_bubble  [2];
    logic        busy      [2];
    logic [1:0]  mstat     [2];
    logic [63:0] mvalm     [2];
    logic [3:0]  w_icode   [2];
    logic [3:0]  w_dste    [2];
    logic [3:0]  w_dstm    [2];
    logic [63:0] w_vale    [2];
    logic [63:0] w_valm    [2];
    logic [1:0]  w_stat    [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            mem_stage_lat #(.DATA_W(64), .MEM_BYTES(1024), .MEM_LAT(gi * 2)) u_dut (
                .clk     (clk),
                .rst_n   (rst_n),
                .M_icode (m_icode[gi]),
                .M_valA  (m_vala[gi]),
                .M_valE  (m_vale[gi]),
                .M_dstE  (m_dste[gi]),
                .M_dstM  (m_dstm[gi]),
                .M_stat  (m_stat_in[gi]),
                .W_stall (w_stall[gi]),
                .W_bubble(w_bubble[gi]),
                .m_busy  (busy[gi]),
                .m_stat  (mstat[gi]),
                .m_valM  (mvalm[gi]),
                .W_icode (w_icode[gi]),
                .W_dstE  (w_dste[gi]),
                .W_dstM  (w_dstm[gi]),
                .W_valE  (w_vale[gi]),
                .W_valM  (w_valm[gi]),
                .W_stat  (w_stat[gi])
            );
        end
    endgenerate

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic tracked  [2] = '{1'b0, 1'b0};
    logic pend     [2] = '{1'b0, 1'b0};
    logic pend_nop [2] = '{1'b0, 1'b0};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: a W load is due on the edge after a tracked op was seen complete.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (pend[d]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL d%0d W_load: got a W load expected none queued", d);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("d%0d W_tag", d), 64'(d), 64'(e.dut));
                    chk($sformatf("d%0d W_icode", d), 64'(w_icode[d]), 64'(e.icode));
                    chk($sformatf("d%0d W_valE", d), w_vale[d], e.vale);
                    chk($sformatf("d%0d W_valM", d), w_valm[d], e.valm);
                    chk($sformatf("d%0d W_dstE", d), 64'(w_dste[d]), 64'(e.dste));
                    chk($sformatf("d%0d W_dstM", d), 64'(w_dstm[d]), 64'(e.dstm));
                    chk($sformatf("d%0d W_stat", d), 64'(w_stat[d]), 64'(e.stat));
                    $display("d%0d W icode=%0h valE=%0h valM=%0h stat=%0d", d, w_icode[d], w_vale[d], w_valm[d], w_stat[d]);
                end
            end
            if (pend_nop[d]) begin
                chk($sformatf("d%0d busy_W_icode", d), 64'(w_icode[d]), 64'h1);
                chk($sformatf("d%0d busy_W_dstE", d), 64'(w_dste[d]), 64'hF);
                chk($sformatf("d%0d busy_W_valE", d), w_vale[d], 64'h0);
            end
            pend[d]     = rst_n && tracked[d] && !busy[d] && !w_stall[d] && !w_bubble[d];
            pend_nop[d] = rst_n && tracked[d] && busy[d] && !w_stall[d] && !w_bubble[d];
        end
    end

    task automatic drive(input int d, input logic [3:0] icode, input logic [63:0] vala, input logic [63:0] vale,
                         input logic [3:0] dste, input logic [3:0] dstm, input logic [1:0] st);
        m_icode[d]   = icode;
        m_vala[d]    = vala;
        m_vale[d]    = vale;
        m_dste[d]    = dste;
        m_dstm[d]    = dstm;
        m_stat_in[d] = st;
    endtask

    task automatic drive_nop(input int d);
        drive(d, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF, 2'd0);
    endtask

    task automatic run_instr(input int d, input logic [3:0] icode, input logic [63:0] vala, input logic [63:0] vale,
                             input logic [3:0] dste, input logic [3:0] dstm, input logic [1:0] st,
                             input logic [63:0] exp_valm, input logic [1:0] exp_stat,
                             input int stall_at, input int stall_len,
                             input logic [3:0] hold_icode, input logic [63:0] hold_vale,
                             input int exp_busy, input int exp_cyc);
        exp_t e;
        logic done;
        int   busy_n;
        int   cyc_n;
        e = '{dut: 1'(d), icode: icode, vale: vale, valm: exp_valm, dste: dste, dstm: dstm, stat: exp_stat};
        exp_q.push_back(e);
        drive(d, icode, vala, vale, dste, dstm, st);
        tracked[d] = 1'b1;
        done   = 1'b0;
        busy_n = 0;
        cyc_n  = 0;
        for (int c = 0; c < 40; c++) begin
            w_stall[d] = (c >= stall_at) && (c < stall_at + stall_len);
            @(negedge clk);
            if (c == 0) chk($sformatf("d%0d m_stat", d), 64'(mstat[d]), 64'(exp_stat));
            if (w_stall[d]) begin
                chk($sformatf("d%0d hold_W_icode", d), 64'(w_icode[d]), 64'(hold_icode));
                chk($sformatf("d%0d hold_W_valE", d), w_vale[d], hold_vale);
            end
            if (busy[d]) busy_n++;
            done = !busy[d] && !w_stall[d];
            if (done) chk($sformatf("d%0d m_valM", d), mvalm[d], exp_valm);
            @(posedge clk);
            #1;
            cyc_n++;
            if (done) break;
        end
        w_stall[d] = 1'b0;
        tracked[d] = 1'b0;
        drive_nop(d);
        chk($sformatf("d%0d op_done", d), 64'(done), 64'h1);
        chk($sformatf("d%0d busy_cycles", d), 64'(busy_n), 64'(exp_busy));
        chk($sformatf("d%0d op_cycles", d), 64'(cyc_n), 64'(exp_cyc));
    endtask

    task automatic op(input int d, input logic [3:0] icode, input logic [63:0] vala, input logic [63:0] vale,
                      input logic [3:0] dste, input logic [3:0] dstm, input logic [1:0] st,
                      input logic [63:0] exp_valm, input logic [1:0] exp_stat, input int exp_busy);
        run_instr(d, icode, vala, vale, dste, dstm, st, exp_valm, exp_stat, 0, 0, 4'h0, 64'h0, exp_busy, exp_busy + 1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            drive_nop(d);
            w_stall[d]  = 1'b0;
            w_bubble[d] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d rst_W_icode", d), 64'(w_icode[d]), 64'h1);
            chk($sformatf("d%0d rst_W_dstE", d), 64'(w_dste[d]), 64'hF);
            chk($sformatf("d%0d rst_W_dstM", d), 64'(w_dstm[d]), 64'hF);
            chk($sformatf("d%0d rst_W_valE", d), w_vale[d], 64'h0);
            chk($sformatf("d%0d rst_W_valM", d), w_valm[d], 64'h0);
            chk($sformatf("d%0d rst_W_stat", d), 64'(w_stat[d]), 64'h0);
            chk($sformatf("d%0d rst_busy", d), 64'(busy[d]), 64'h0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-cycle instance
        op(0, 4'h4, 64'd100, 64'd24, 4'hF, 4'hF, 2'd0, 64'd0, 2'd0, 0);
        op(0, 4'h5, 64'd0, 64'd24, 4'hF, 4'h3, 2'd0, 64'd100, 2'd0, 0);
        op(0, 4'h4, 64'h1122334455667788, 64'd176, 4'hF, 4'hF, 2'd0, 64'd0, 2'd0, 0);
        op(0, 4'h5, 64'd0, 64'd1200, 4'hF, 4'h4, 2'd0, 64'd0, 2'd2, 0);
        op(0, 4'h5, 64'd0, 64'd176, 4'hF, 4'h4, 2'd0, 64'h1122334455667788, 2'd0, 0);
        op(0, 4'h4, 64'hABCD, 64'd1016, 4'hF, 4'hF, 2'd0, 64'd0, 2'd0, 0);
        op(0, 4'h5, 64'd0, 64'd1016, 4'hF, 4'h2, 2'd0, 64'hABCD, 2'd0, 0);
        op(0, 4'h5, 64'd0, 64'd1017, 4'hF, 4'h2, 2'd0, 64'd0, 2'd2, 0);
        op(0, 4'h5, 64'd0, 64'h8000000000000018, 4'hF, 4'h2, 2'd0, 64'd0, 2'd2, 0);
        op(0, 4'h4, 64'd999, 64'd24, 4'hF, 4'hF, 2'd1, 64'd0, 2'd1, 0);
        op(0, 4'h5, 64'd0, 64'd24, 4'hF, 4'h3, 2'd0, 64'd100, 2'd0, 0);
        op(0, 4'h4, 64'h0102030405060708, 64'd100, 4'hF, 4'hF, 2'd0, 64'd0, 2'd0, 0);
        op(0, 4'h4, 64'h1112131415161718, 64'd108, 4'hF, 4'hF, 2'd0, 64'd0, 2'd0, 0);
        op(0, 4'h5, 64'd0, 64'd104, 4'hF, 4'h2, 2'd0, 64'h1516171801020304, 2'd0, 0);
        run_instr(0, 4'h5, 64'd0, 64'd24, 4'hF, 4'h5, 2'd0, 64'd100, 2'd0, 0, 2, 4'h5, 64'd104, 0, 3);

        // Bubble suppresses the store and loads a nop into W
        op(0, 4'h4, 64'd55, 64'd200, 4'hF, 4'hF, 2'd0, 64'd0, 2'd0, 0);
        drive(0, 4'h4, 64'd77, 64'd200, 4'hF, 4'hF, 2'd0);
        w_bubble[0] = 1'b1;
        @(posedge clk);
        #1;
        w_bubble[0] = 1'b0;
        drive_nop(0);
        @(negedge clk);
        chk("d0 bubble_W_icode", 64'(w_icode[0]), 64'h1);
        chk("d0 bubble_W_valE", w_vale[0], 64'h0);
        @(posedge clk);
        #1;
        op(0, 4'h5, 64'd0, 64'd200, 4'hF, 4'h1, 2'd0, 64'd55, 2'd0, 0);

        // Two-wait-cycle instance
        op(1, 4'hA, 64'd10, 64'd20, 4'h4, 4'hF, 2'd0, 64'd0, 2'd0, 2);
        op(1, 4'hB, 64'd20, 64'd28, 4'h4, 4'h0, 2'd0, 64'd10, 2'd0, 2);
        run_instr(1, 4'h4, 64'hDEAD, 64'd300, 4'hF, 4'hF, 2'd0, 64'd0, 2'd0, 1, 3, 4'h1, 64'd0, 5, 6);
        op(1, 4'h5, 64'd0, 64'd300, 4'hF, 4'h6, 2'd0, 64'hDEAD, 2'd0, 2);
        op(1, 4'h8, 64'd32, 64'd0, 4'h4, 4'hF, 2'd0, 64'd0, 2'd0, 2);
        op(1, 4'h9, 64'd0, 64'd8, 4'h4, 4'hF, 2'd0, 64'd32, 2'd0, 2);

        // Reset while a store waits: W clears at once and the store is lost
        op(1, 4'h4, 64'd111, 64'd400, 4'hF, 4'hF, 2'd0, 64'd0, 2'd0, 2);
        op(1, 4'h5, 64'd0, 64'd400, 4'hF, 4'h7, 2'd0, 64'd111, 2'd0, 2);
        drive(1, 4'h4, 64'd222, 64'd400, 4'hF, 4'hF, 2'd0);
        w_stall[1] = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("d1 wait_busy", 64'(busy[1]), 64'h1);
        chk("d1 wait_W_icode", 64'(w_icode[1]), 64'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("d1 arst_W_icode", 64'(w_icode[1]), 64'h1);
        chk("d1 arst_W_dstM", 64'(w_dstm[1]), 64'hF);
        chk("d1 arst_W_valE", w_vale[1], 64'h0);
        chk("d1 arst_W_valM", w_valm[1], 64'h0);
        chk("d1 arst_W_stat", 64'(w_stat[1]), 64'h0);
        @(posedge clk);
        #1;
        drive_nop(1);
        w_stall[1] = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        op(1, 4'h5, 64'd0, 64'd400, 4'hF, 4'h7, 2'd0, 64'd111, 2'd0, 2);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
